// File: rtl/gray_step_decoder.sv
// gray_step_decoder: resynchronises a Gray count and decodes it to binary.
// It classifies each change as a step, hold or illegal jump, and tracks position and errors with a sticky fault.
module gray_step_decoder #(
  parameter int WIDTH       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int POS_WIDTH   = 8,
  parameter int ERR_LIMIT   = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 clear,
  output logic [WIDTH-1:0]     binary_out,
  output logic [POS_WIDTH-1:0] position,
  output logic                 dir_up,
  output logic                 step_valid,
  output logic                 step_err,
  output logic [7:0]           err_count,
  output logic                 fault
);
  typedef enum logic [1:0] {INIT, TRACK, FAULT} state_t;
  localparam logic [2:0] FLUSH = 3'(SYNC_STAGES);
  localparam logic [7:0] LIMIT = 8'(ERR_LIMIT);
  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  logic [WIDTH-1:0]     r_sync [SYNC_STAGES];
  logic [WIDTH-1:0]     r_prev;
  logic [WIDTH-1:0]     r_bin;
  logic [POS_WIDTH-1:0] r_pos;
  logic                 r_dir;
  logic                 r_sv;
  logic                 r_se;
  logic [7:0]           r_err;
  logic                 r_fault;
  logic [2:0]           r_cnt;
  state_t               r_state;
  logic [WIDTH-1:0]     w_gs;
  logic [WIDTH-1:0]     w_diff;
  logic                 w_one;
  logic                 w_zero;
  logic                 w_up;
  logic [7:0]           w_err_nxt;
  assign w_gs      = r_sync[SYNC_STAGES-1];
  assign w_diff    = w_gs ^ r_prev;
  assign w_one     = $onehot(w_diff);
  assign w_zero    = ~|w_diff;
  assign w_up      = g2b(w_gs) == g2b(r_prev) + WIDTH'(1);
  assign w_err_nxt = (r_err == 8'hFF) ? r_err : r_err + 8'd1;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end
  // INIT waits one cycle past the chain depth so prev never sees a reset-flushed zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev  <= '0;
      r_bin   <= '0;
      r_pos   <= '0;
      r_dir   <= 1'b1;
      r_sv    <= 1'b0;
      r_se    <= 1'b0;
      r_err   <= '0;
      r_fault <= 1'b0;
      r_cnt   <= '0;
      r_state <= INIT;
    end else begin
      r_bin <= g2b(w_gs);
      r_sv  <= 1'b0;
      r_se  <= 1'b0;
      if (clear) begin
        r_pos   <= '0;
        r_err   <= '0;
        r_fault <= 1'b0;
        r_cnt   <= '0;
        r_state <= INIT;
      end else begin
        case (r_state)
          INIT: begin
            if (r_cnt == FLUSH) begin
              r_prev  <= w_gs;
              r_state <= TRACK;
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end
          TRACK: begin
            if (w_one) begin
              r_sv   <= 1'b1;
              r_prev <= w_gs;
              r_dir  <= w_up;
              r_pos  <= w_up ? r_pos + POS_WIDTH'(1) : r_pos - POS_WIDTH'(1);
            end else if (!w_zero) begin
              r_se   <= 1'b1;
              r_prev <= w_gs;
              r_err  <= w_err_nxt;
              if (w_err_nxt >= LIMIT) begin
                r_fault <= 1'b1;
                r_state <= FAULT;
              end
            end
          end
          default: r_prev <= w_gs;
        endcase
      end
    end
  end
  assign binary_out = r_bin;
  assign position   = r_pos;
  assign dir_up     = r_dir;
  assign step_valid = r_sv;
  assign step_err   = r_se;
  assign err_count  = r_err;
  assign fault      = r_fault;
endmodule

// File: tb/tb_gray_step_decoder.sv
// tb_gray_step_decoder: directed scenarios plus a randomized walk checked against a behavioural model.
module tb_gray_step_decoder;
  localparam int S = 2;
  localparam int LIM = 3;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] gray_in = 3'b000;
  logic       clear = 1'b0;
  logic [2:0] binary_out;
  logic [7:0] position;
  logic       dir_up, step_valid, step_err, fault;
  logic [7:0] err_count;
  int n_cmp = 0;
  int n_bad = 0;
  int nv, ne;
  gray_step_decoder #(.WIDTH(3), .SYNC_STAGES(S), .POS_WIDTH(8), .ERR_LIMIT(LIM)) dut (
    .clk(clk), .reset_n(reset_n), .gray_in(gray_in), .clear(clear),
    .binary_out(binary_out), .position(position), .dir_up(dir_up),
    .step_valid(step_valid), .step_err(step_err), .err_count(err_count), .fault(fault)
  );
  always #5 clk = ~clk;
  function automatic int g2b(input logic [2:0] g);
    for (int i = 0; i < 8; i++) if (3'(i ^ (i >> 1)) == g) return i;
    return 0;
  endfunction
  function automatic logic [2:0] b2g(input int b);
    return 3'((b % 8) ^ ((b % 8) >> 1));
  endfunction
  // reference model: history of sampled inputs, decision rules applied on the delayed code
  logic [2:0] m_hist [$];
  int         m_mode, m_wait, m_pos, m_err, m_bin;
  logic [2:0] m_prev;
  logic       m_dir, m_sv, m_se, m_fault;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hist.delete();
      m_mode = 0; m_wait = S; m_pos = 0; m_err = 0; m_bin = 0;
      m_prev = 3'b000; m_dir = 1'b1; m_sv = 1'b0; m_se = 1'b0; m_fault = 1'b0;
    end else begin
      logic [2:0] g;
      g = (m_hist.size() >= S) ? m_hist[m_hist.size() - S] : 3'b000;
      m_hist.push_back(gray_in);
      m_bin = g2b(g);
      m_sv = 1'b0;
      m_se = 1'b0;
      if (clear) begin
        m_pos = 0; m_err = 0; m_fault = 1'b0; m_mode = 0; m_wait = S;
      end else if (m_mode == 0) begin
        if (m_wait == 0) begin m_prev = g; m_mode = 1; end
        else m_wait--;
      end else if (m_mode == 1) begin
        if ($countones(g ^ m_prev) == 1) begin
          m_sv = 1'b1;
          m_dir = ((g2b(g) - g2b(m_prev) + 8) % 8) == 1;
          m_pos = m_pos + (m_dir ? 1 : -1);
          m_prev = g;
        end else if (g != m_prev) begin
          m_se = 1'b1;
          m_prev = g;
          if (m_err < 255) m_err++;
          if (m_err >= LIM) begin m_mode = 2; m_fault = 1'b1; end
        end
      end else begin
        m_prev = g;
      end
    end
  end
  task automatic drive(input logic [2:0] g, input logic c, input int n);
    for (int i = 0; i < n; i++) begin
      gray_in = g;
      clear = c;
      @(posedge clk);
      #1;
      nv += int'(step_valid);
      ne += int'(step_err);
    end
    clear = 1'b0;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    gray_in = 3'b000;
    #2;
    reset_n = 1'b1;
    drive(3'b000, 1'b0, 4);
    nv = 0;
    ne = 0;
  endtask
  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({binary_out, position, dir_up, step_valid, step_err, err_count, fault} !== {3'b000, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state: got bin=%b pos=%h dir=%b sv=%b se=%b err=%0d flt=%b, want 000 00 1 0 0 0 0", binary_out, position, dir_up, step_valid, step_err, err_count, fault);
    end
  endtask
  task automatic test_up_count();
    logic [2:0] seq [5] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110};
    do_reset();
    foreach (seq[i]) drive(seq[i], 1'b0, 2);
    drive(3'b110, 1'b0, 3);
    n_cmp++;
    if ({nv, position, dir_up, binary_out, err_count} !== {32'd4, 8'd4, 1'b1, 3'b100, 8'd0}) begin
      n_bad++;
      $display("FAIL up_count: got pulses=%0d pos=%0d dir=%b bin=%b err=%0d, want 4 4 1 100 0", nv, position, dir_up, binary_out, err_count);
    end
  endtask
  task automatic test_down_wrap();
    do_reset();
    drive(3'b100, 1'b0, 4);
    n_cmp++;
    if (binary_out !== 3'b111) begin
      n_bad++;
      $display("FAIL down_wrap_bin1: got %b want 111", binary_out);
    end
    drive(3'b101, 1'b0, 4);
    n_cmp++;
    if ({binary_out, position, dir_up, nv} !== {3'b110, 8'hFE, 1'b0, 32'd2}) begin
      n_bad++;
      $display("FAIL down_wrap: got bin=%b pos=%h dir=%b pulses=%0d, want 110 fe 0 2", binary_out, position, dir_up, nv);
    end
  endtask
  task automatic test_full_cycle();
    do_reset();
    for (int k = 1; k <= 8; k++) drive(b2g(k), 1'b0, 3);
    n_cmp++;
    if ({binary_out, position, dir_up, nv} !== {3'b000, 8'd8, 1'b1, 32'd8}) begin
      n_bad++;
      $display("FAIL full_cycle: got bin=%b pos=%0d dir=%b pulses=%0d, want 000 8 1 8", binary_out, position, dir_up, nv);
    end
  endtask
  task automatic test_illegal();
    do_reset();
    drive(3'b011, 1'b0, 4);
    n_cmp++;
    if ({ne, nv, err_count, position, binary_out} !== {32'd1, 32'd0, 8'd1, 8'd0, 3'b010}) begin
      n_bad++;
      $display("FAIL illegal_jump: got errp=%0d stepp=%0d err=%0d pos=%0d bin=%b, want 1 0 1 0 010", ne, nv, err_count, position, binary_out);
    end
    drive(3'b010, 1'b0, 4);
    n_cmp++;
    if ({nv, binary_out, position, dir_up} !== {32'd1, 3'b011, 8'd1, 1'b1}) begin
      n_bad++;
      $display("FAIL after_jump_step: got pulses=%0d bin=%b pos=%0d dir=%b, want 1 011 1 1", nv, binary_out, position, dir_up);
    end
  endtask
  task automatic test_fault_clear();
    do_reset();
    drive(3'b001, 1'b0, 4);
    drive(3'b010, 1'b0, 4);
    drive(3'b001, 1'b0, 4);
    drive(3'b010, 1'b0, 4);
    n_cmp++;
    if ({fault, err_count, ne, position} !== {1'b1, 8'd3, 32'd3, 8'd1}) begin
      n_bad++;
      $display("FAIL fault_entry: got flt=%b err=%0d errp=%0d pos=%0d, want 1 3 3 1", fault, err_count, ne, position);
    end
    nv = 0; ne = 0;
    drive(3'b011, 1'b0, 4);
    n_cmp++;
    if ({nv, ne, position, fault, binary_out} !== {32'd0, 32'd0, 8'd1, 1'b1, 3'b010}) begin
      n_bad++;
      $display("FAIL fault_frozen: got stepp=%0d errp=%0d pos=%0d flt=%b bin=%b, want 0 0 1 1 010", nv, ne, position, fault, binary_out);
    end
    drive(3'b001, 1'b1, 1);
    n_cmp++;
    if ({position, err_count, fault} !== {8'd0, 8'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL clear_edge: got pos=%0d err=%0d flt=%b, want 0 0 0", position, err_count, fault);
    end
    drive(3'b001, 1'b0, 6);
    n_cmp++;
    if ({nv, ne, position} !== {32'd0, 32'd0, 8'd0}) begin
      n_bad++;
      $display("FAIL clear_discard: got stepp=%0d errp=%0d pos=%0d, want 0 0 0", nv, ne, position);
    end
    drive(3'b000, 1'b0, 4);
    n_cmp++;
    if ({nv, position, dir_up} !== {32'd1, 8'hFF, 1'b0}) begin
      n_bad++;
      $display("FAIL clear_resume: got pulses=%0d pos=%h dir=%b, want 1 ff 0", nv, position, dir_up);
    end
  endtask
  task automatic test_pos_wrap();
    do_reset();
    for (int k = 1; k <= 127; k++) drive(b2g(k), 1'b0, 1);
    drive(b2g(127), 1'b0, 3);
    n_cmp++;
    if (position !== 8'h7F) begin
      n_bad++;
      $display("FAIL pos_max: got %h want 7f", position);
    end
    drive(b2g(128), 1'b0, 3);
    n_cmp++;
    if ({position, nv} !== {8'h80, 32'd128}) begin
      n_bad++;
      $display("FAIL pos_wrap: got pos=%h pulses=%0d, want 80 128", position, nv);
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    for (int k = 1; k <= 5; k++) drive(b2g(k), 1'b0, 2);
    drive(b2g(5), 1'b0, 3);
    n_cmp++;
    if (position !== 8'd5) begin
      n_bad++;
      $display("FAIL mid_setup: got pos=%0d want 5", position);
    end
    #3;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({binary_out, position, dir_up, step_valid, step_err, err_count, fault} !== {3'b000, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      n_bad++;
      $display("FAIL async_reset: got bin=%b pos=%h dir=%b sv=%b se=%b err=%0d flt=%b, want 000 00 1 0 0 0 0", binary_out, position, dir_up, step_valid, step_err, err_count, fault);
    end
    gray_in = 3'b010;
    #1;
    reset_n = 1'b1;
    nv = 0; ne = 0;
    drive(3'b010, 1'b0, 8);
    n_cmp++;
    if ({nv, ne, binary_out, position} !== {32'd0, 32'd0, 3'b011, 8'd0}) begin
      n_bad++;
      $display("FAIL post_reset_init: got stepp=%0d errp=%0d bin=%b pos=%0d, want 0 0 011 0", nv, ne, binary_out, position);
    end
  endtask
  task automatic test_random();
    int k, r;
    do_reset();
    k = 0;
    for (int c = 0; c < 400; c++) begin
      r = $urandom_range(0, 19);
      if (r < 5) k = (k + 1) % 8;
      else if (r < 10) k = (k + 7) % 8;
      else if (r < 14) k = $urandom_range(0, 7);
      drive(b2g(k), r == 18, 1);
      n_cmp++;
      if ({binary_out, position, dir_up, step_valid, step_err, err_count, fault} !== {3'(m_bin), 8'(m_pos), m_dir, m_sv, m_se, 8'(m_err), m_fault}) begin
        n_bad++;
        $display("FAIL random_c%0d: got bin=%b pos=%h dir=%b sv=%b se=%b err=%0d flt=%b, want %b %h %b %b %b %0d %b", c, binary_out, position, dir_up, step_valid, step_err, err_count, fault, 3'(m_bin), 8'(m_pos), m_dir, m_sv, m_se, m_err, m_fault);
      end
    end
  endtask
  initial begin
    nv = 0;
    ne = 0;
    test_reset();
    test_up_count();
    test_down_wrap();
    test_full_cycle();
    test_illegal();
    test_fault_clear();
    test_pos_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gray_step_decoder.md
Name: gray_step_decoder

Overview:
- Consumes the 3-bit Gray-coded count from the up/down Gray counter. It may sit across a clock boundary.
- Resynchronises the code, then decodes it to binary.
- Classifies each change as up step, down step, hold or illegal jump.
- Keeps a signed position accumulator and a saturating error count, with a sticky fault state.

Parameters:
- WIDTH, 3, Gray/binary code width.
- SYNC_STAGES, 2, synchroniser flops on gray_in; legal range 1-4.
- POS_WIDTH, 8, width of the signed position accumulator.
- ERR_LIMIT, 3, number of illegal jumps that forces FAULT; legal range 1-255.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- gray_in  input  WIDTH  Gray code from the counter; may be asynchronous to clk.
- clear  input  1  synchronous clear of position, err_count and fault; re-initialises tracking.
- binary_out  output  WIDTH  binary decode of the synchronised code (b[W-1]=g[W-1], b[i]=b[i+1]^g[i]).
- position  output  POS_WIDTH  signed step accumulator, two's complement.
- dir_up  output  1  direction of the last valid step (1=up).
- step_valid  output  1  one-cycle pulse per accepted single-bit step.
- step_err  output  1  one-cycle pulse per illegal multi-bit jump.
- err_count  output  8  saturating count of illegal jumps.
- fault  output  1  high while in FAULT.

Behaviour:
- Reset (reset_n low): takes effect immediately, no clock required.
  - Sync flops, prev register and binary_out = 0; position = 0; dir_up = 1.
  - step_valid = step_err = 0; err_count = 0; fault = 0; state = INIT; init counter = 0.
- Synchroniser: SYNC_STAGES-deep flop chain; g_s is the last stage.
- Latency:
  - A gray_in value captured at edge t0 is reflected in binary_out, step_valid, step_err and position after edge t0+SYNC_STAGES.
  - With SYNC_STAGES=2 this is the third rising edge counting t0.
- States:
  - INIT: counts SYNC_STAGES cycles to flush the chain, then loads prev<=g_s and goes to TRACK. No step or err pulses are generated in INIT. binary_out still tracks g_s.
  - TRACK: each cycle, compute the Hamming distance d between g_s and prev.
    - d=0: hold; no pulses.
    - d=1: step_valid=1; prev<=g_s.
      - Up step if bin(g_s)==bin(prev)+1 mod 2^WIDTH: dir_up<=1, position+=1.
      - Otherwise down step: dir_up<=0, position-=1.
    - d>=2: step_err=1; prev<=g_s (resync).
      - position and dir_up are unchanged.
      - err_count increments, saturating at 255.
      - If the new err_count >= ERR_LIMIT, go to FAULT (fault=1 from the same edge).
  - FAULT: prev keeps tracking g_s and binary_out keeps updating.
    - position and dir_up are frozen.
    - step_valid and step_err are never asserted; err_count is frozen.
    - Exit only via clear.
- clear (any state): on the next edge, position=0, err_count=0, fault=0, state=INIT, init counter=0.
  - dir_up is unchanged.
  - clear wins over a simultaneous step or error: that step is discarded, with no pulse.
- Code wrap: 111->...->100->000 (binary 7->0) is a legal up step; 000->100 (binary 0->7) is a legal down step.
- Position overflow wraps in two's complement with no flag: +127 plus one up step gives -128.
- reset_n asserted mid-operation: all state is lost immediately. After release the block re-enters INIT; the first post-reset code is never counted as a step.
- step_valid and step_err are mutually exclusive and each lasts exactly one cycle.

Test Plan:
1. Up count: reset, release, wait for INIT to finish. Drive gray_in 000,001,011,010,110, holding each value 2 cycles.
   -> 4 step_valid pulses; position=4; dir_up=1; binary_out=100; err_count=0.
2. Down and wrap: from 000, drive 100, then 101.
   -> binary_out 111 then 110; position=8'hFE (-2); dir_up=0; 2 step_valid pulses.
3. Full up cycle: 8 legal up steps starting from 000.
   -> binary_out returns to 000; position=8; the 100->000 transition counted as up.
4. Illegal jump: TRACK at 000, drive 011.
   -> step_err single pulse; err_count=1; position unchanged.
   Then drive 010 -> step_valid; binary 2->3; position+1; dir_up=1.
5. Fault and clear (ERR_LIMIT=3): three jumps 000->011->000->011.
   -> fault=1 after the third step_err.
   Then a legal step 011->010 -> position unchanged, no step_valid.
   Assert clear one cycle together with a legal step -> position=0, err_count=0, fault=0, no pulse; INIT flush, then tracking resumes.
6. Reset mid-operation: position=5; pull reset_n low between clock edges.
   -> all outputs 0 (dir_up=1) before the next edge.
   After release, hold gray_in=010 -> no step_valid during INIT; binary_out=011; position stays 0.
